// File: rtl/divide_seq.sv
// divide_seq: unsigned sequential restoring divider.
//   Produces floor(dividend/divisor) and dividend mod divisor, one quotient bit per
//   clock (MSB first). start/busy/done handshake; a divide by zero finishes at once
//   with quotient=all ones, remainder=dividend and div_by_zero set.
// Ports:
//   clk          rising-edge clock
//   nReset       asynchronous active-low reset
//   start        request, accepted when busy==0 (IDLE or FINISH)
//   dividend     numerator, sampled on the accepting edge
//   divisor      denominator, sampled on the accepting edge
//   busy         high while iterating
//   done         one-cycle result-valid pulse
//   quotient     result quotient, held until the next accepted start
//   remainder    result remainder, held until the next accepted start
//   div_by_zero  set with done when divisor was zero, held with the results
module divide_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    // num starts as the dividend; each step shifts one dividend bit out of the
    // top and one quotient bit into the bottom, so it ends holding the quotient.
    logic [WIDTH-1:0] num;
    logic [WIDTH-1:0] den;
    // Partial remainder is always < divisor between steps, so WIDTH bits suffice
    // to store it; the shifted value needs WIDTH+1.
    logic [WIDTH-1:0] wr;
    logic [WIDTH:0]   rsh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rnext;
    logic             qbit;
    logic             last;
    logic             accept;

    // One restoring step. rsh <= 2*den-1, so trial lies in [-den, den-1] and its
    // top bit is a valid sign.
    always_comb begin
        rsh    = {wr, num[WIDTH-1]};
        trial  = rsh - {1'b0, den};
        qbit   = ~trial[WIDTH];
        rnext  = qbit ? trial[WIDTH-1:0] : rsh[WIDTH-1:0];
        last   = (cnt == CW'(WIDTH - 1));
        accept = start && (state != RUN);
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_n = (divisor == '0) ? FINISH : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_n = FINISH;
            end
            FINISH: begin
                done = 1'b1;
                // A new request here overlaps the done pulse of the old one.
                if (start) state_n = (divisor == '0) ? FINISH : RUN;
                else       state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            cnt         <= '0;
            num         <= '0;
            den         <= '0;
            wr          <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt <= '0;
            num <= dividend;
            den <= divisor;
            wr  <= '0;
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                div_by_zero <= 1'b0;
            end
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
            num <= {num[WIDTH-2:0], qbit};
            wr  <= rnext;
            // Visible results only move on the final step, so they hold
            // through the run until the new answer is ready.
            if (last) begin
                quotient  <= {num[WIDTH-2:0], qbit};
                remainder <= rnext;
            end
        end
    end

endmodule

// File: tb/tb_divide_seq.sv
module tb_divide_seq;

    logic        clk;
    logic        nReset;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

    divide_seq #(.WIDTH(16)) dut (
        .clk         (clk),
        .nReset      (nReset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Caller is at a negedge; start is seen by the next rising edge only.
    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts negedges after the accepting edge until done (k=0 on timeout).
    task automatic wait_done(output int k, output int nb);
        k  = 0;
        nb = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        nReset = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        #5;
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 35'd0) begin
            failures++;
            $display("FAIL reset_hold got b=%b d=%b z=%b q=%h r=%h want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        repeat (3) @(negedge clk);
        nReset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 35'd0) begin
            failures++;
            $display("FAIL reset_release got b=%b d=%b z=%b q=%h r=%h want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
    endtask

    task automatic test_basic();
        int k, nb;
        @(negedge clk);
        issue(16'h0025, 16'h0003);
        wait_done(k, nb);
        checks++;
        if (k !== 17) begin failures++; $display("FAIL basic_latency got %0d want 17", k); end
        checks++;
        if (nb !== 16) begin failures++; $display("FAIL basic_busy_cycles got %0d want 16", nb); end
        checks++;
        if ({quotient, remainder, div_by_zero} !== {16'h000C, 16'h0001, 1'b0}) begin
            failures++;
            $display("FAIL basic_result got q=%h r=%h z=%b want q=000c r=0001 z=0",
                     quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got %b want 0", done); end
        repeat (3) @(negedge clk);
        checks++;
        if ({quotient, remainder} !== {16'h000C, 16'h0001}) begin
            failures++;
            $display("FAIL basic_hold got q=%h r=%h want q=000c r=0001", quotient, remainder);
        end
    endtask

    task automatic test_edges();
        logic [15:0] a [3] = '{16'hFFFF, 16'h0005, 16'h0000};
        logic [15:0] b [3] = '{16'h0001, 16'h0007, 16'h0005};
        logic [15:0] eq[3] = '{16'hFFFF, 16'h0000, 16'h0000};
        logic [15:0] er[3] = '{16'h0000, 16'h0005, 16'h0000};
        int k, nb;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            issue(a[i], b[i]);
            wait_done(k, nb);
            checks++;
            if (k !== 17 || quotient !== eq[i] || remainder !== er[i]) begin
                failures++;
                $display("FAIL edge_%0d got k=%0d q=%h r=%h want k=17 q=%h r=%h",
                         i, k, quotient, remainder, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        int k, nb;
        @(negedge clk);
        issue(16'h1234, 16'h0000);
        wait_done(k, nb);
        checks++;
        if (k !== 1 || nb !== 0) begin
            failures++;
            $display("FAIL dbz_timing got k=%0d busy_cycles=%0d want k=1 busy_cycles=0", k, nb);
        end
        checks++;
        if ({quotient, remainder, div_by_zero} !== {16'hFFFF, 16'h1234, 1'b1}) begin
            failures++;
            $display("FAIL dbz_result got q=%h r=%h z=%b want q=ffff r=1234 z=1",
                     quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || div_by_zero !== 1'b1) begin
            failures++;
            $display("FAIL dbz_hold got done=%b z=%b want done=0 z=1", done, div_by_zero);
        end
        issue(16'd8, 16'd2);
        wait_done(k, nb);
        checks++;
        if (k !== 17 || quotient !== 16'd4 || remainder !== 16'd0 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL dbz_clear got k=%0d q=%h r=%h z=%b want k=17 q=0004 r=0000 z=0",
                     k, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_ignore_start();
        int ndone = 0;
        int first = 0;
        logic [15:0] q, r;
        @(negedge clk);
        issue(16'd100, 16'd7);
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (i == 5) begin
                dividend = 16'd9; divisor = 16'd3; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                if (first == 0) begin first = i; q = quotient; r = remainder; end
            end
        end
        checks++;
        if (ndone !== 1 || first !== 17) begin
            failures++;
            $display("FAIL ignore_done_count got n=%0d at=%0d want n=1 at=17", ndone, first);
        end
        checks++;
        if (q !== 16'd14 || r !== 16'd2) begin
            failures++;
            $display("FAIL ignore_result got q=%0d r=%0d want q=14 r=2", q, r);
        end
    endtask

    task automatic test_reset_abort();
        int ndone = 0;
        int k, nb;
        @(negedge clk);
        issue(16'h8000, 16'h0003);
        repeat (8) @(negedge clk);
        nReset = 1'b0;
        #1;
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 35'd0) begin
            failures++;
            $display("FAIL abort_outputs got b=%b d=%b z=%b q=%h r=%h want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        repeat (2) @(negedge clk);
        nReset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            failures++;
            $display("FAIL abort_no_done got %0d active cycles want 0", ndone);
        end
        issue(16'h8000, 16'h0003);
        wait_done(k, nb);
        checks++;
        if (k !== 17 || quotient !== 16'h2AAA || remainder !== 16'h0002) begin
            failures++;
            $display("FAIL abort_retry got k=%0d q=%h r=%h want k=17 q=2aaa r=0002",
                     k, quotient, remainder);
        end
    endtask

    task automatic test_back_to_back();
        int k, nb;
        int bad_res = 0;
        int bad_gap = 0;
        logic [15:0] eq, er;
        @(negedge clk);
        issue(16'h0025, 16'd1);
        for (int d = 1; d <= 255; d++) begin
            wait_done(k, nb);
            eq = 16'(16'h0025 / d);
            er = 16'(16'h0025 % d);
            if (quotient !== eq || remainder !== er || div_by_zero !== 1'b0) begin
                bad_res++;
                if (bad_res <= 3)
                    $display("FAIL b2b_result d=%0d got q=%h r=%h want q=%h r=%h",
                             d, quotient, remainder, eq, er);
            end
            if (k !== 17) begin
                bad_gap++;
                if (bad_gap <= 3) $display("FAIL b2b_spacing d=%0d got %0d want 17", d, k);
            end
            if (k == 0) break;
            if (d < 255) issue(16'h0025, 16'(d + 1));
        end
        checks++;
        if (bad_res !== 0) failures++;
        checks++;
        if (bad_gap !== 0) failures++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_div_zero();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
